apb_reg_ctrl: RTL and testbench
===============================

// Module: apb_reg_ctrl
// PURPOSE
//  APB4 slave front-end for the peripheral status/control register bank at BASE_ADDR.
//  Sequences setup/access phases, decodes PADDR to a word index and inserts wait states.
//  Issues one-cycle rd/wr strobes to the registers; a read strobe doubles as the read-to-clear
//  pulse for counter/status registers. Flags unmapped, misaligned and read-only writes via PSLVERR.
// PARAMETERS
//  BASE_ADDR   32'hC0F16000  APB base of the register window
//  NREG        4             number of 32-bit registers (offsets 0x000..4*(NREG-1)), 1..16
//  WAIT_CYCLES 0             PREADY-low cycles in the access phase, 0..15
//  RO_MASK     4'b0010       bit i=1: register i is read-only (write -> PSLVERR)
// PORTS
//  clk        in   1        single clock; all state on rising edge
//  rstn       in   1        asynchronous, active-low reset
//  psel       in   1        APB select
//  penable    in   1        APB enable (access phase)
//  pwrite     in   1        1=write, 0=read
//  paddr      in   32       byte address
//  pwdata     in   32       write data
//  pstrb      in   4        byte write strobes
//  prdata     out  32       read data; valid when pready&penable&!pwrite
//  pready     out  1        transfer complete
//  pslverr    out  1        error; valid only with pready
//  reg_wr_en  out  NREG     one-hot write strobe, 1 cycle
//  reg_rd_en  out  NREG     one-hot read / read-to-clear strobe, 1 cycle
//  reg_wdata  out  32       pwdata passthrough, qualified by reg_wr_en
//  reg_wstrb  out  4        pstrb passthrough, qualified by reg_wr_en
//  reg_rdata  in   NREG*32  flattened register contents; reg i = [32*i+31:32*i]
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; pready=0, pslverr=0, prdata=0, reg_wr_en=0, reg_rd_en=0.
//  FSM IDLE -> ACCESS -> IDLE.
//   IDLE: psel&!penable (setup) -> latch idx=(paddr-BASE_ADDR)>>2, dir, err; cnt<=WAIT_CYCLES; ->ACCESS.
//   ACCESS: cnt!=0 -> cnt-1, pready=0. cnt==0 -> pready=1 (decoded from state regs, no comb path
//    from APB inputs). Completion = psel&penable&pready -> IDLE.
//   ACCESS with psel=0: protocol abort -> IDLE, no strobes, no PSLVERR.
//  err = addr outside [BASE,BASE+4*NREG-1] | paddr[1:0]!=0 | (pwrite & RO_MASK[idx]); latched at setup.
//  pslverr = pready & err_latched. err: no strobes, prdata=0.
//  Strobes fire only in the completion cycle, !err: reg_rd_en[idx] on reads, reg_wr_en[idx] on writes.
//   Read-to-clear updates at the same edge the master samples prdata: master sees pre-clear value.
//  prdata = reg_rdata word idx while ACCESS & !dir & !err, else 0; no added latency.
//  Paddr/pwrite changes during ACCESS are ignored (latched values used).
//  Back-to-back: completion -> IDLE, next setup accepted next cycle; max 1 transfer per 2 cycles (WAIT_CYCLES=0).
//  pstrb=0 write: still a legal write; strobe issued, register honours reg_wstrb.
//  cnt width $clog2(16); no wrap, counts down only. reset mid-transfer: immediate return to reset values.
// STRUCTURE
//  Package apb_reg_pkg: state enum {IDLE,ACCESS}, APB_DW=32, APB_AW=32, offset consts
//   REG_CTRL_OFS=12'h000, REG_STAT_OFS=12'h004.
//  Sub-module apb_reg_decode (combinational): paddr,pwrite -> idx, hit, misaligned, ro_err.
//  Top: FSM + wait counter + latches + strobe/prdata muxing.
// TESTING
//  Reset: rstn=0 with psel=1 -> pready=0, pslverr=0, prdata=0, strobes=0 throughout.
//  Read 0xC0F16004, WAIT=0, reg1=32'h00003005 -> pready 1st access cycle, prdata=32'h00003005,
//   reg_rd_en=4'b0010 one cycle, no other strobe.
//  Write 0xC0F16000 data 32'hA5 pstrb 4'hF, WAIT=2 -> pready low 2 cycles, high 3rd;
//   reg_wr_en=4'b0001 one cycle, reg_wdata=32'hA5.
//  Errors: read 0xC0F16010 (NREG=4), read 0xC0F16002, write 0xC0F16004 (RO) -> each pready+pslverr=1,
//   prdata=0, strobes=0.
//  Abort: WAIT=3, drop psel after 1 access cycle -> IDLE, no strobes; rstn pulse mid-wait -> outputs 0
//   asynchronously, next transfer normal.
//  Back-to-back reads of 0x004 -> two reg_rd_en pulses 2 cycles apart, second prdata = cleared value.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register-bank front-end.
// Register offsets are relative to the instance's BASE_ADDR.
package apb_reg_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = $clog2(16);

    localparam logic [11:0] REG_CTRL_OFS = 12'h000;
    localparam logic [11:0] REG_STAT_OFS = 12'h004;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational address decode: byte address to word index, plus the three error sources.
// Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both window edges.
module apb_reg_decode
    import apb_reg_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'hC0F16000,
    parameter int                NREG      = 4,
    parameter logic [NREG-1:0]   RO_MASK   = 4'b0010
) (
    input  logic [APB_AW-1:0] paddr,
    input  logic              pwrite,
    output logic [IDX_W-1:0]  idx,
    output logic              hit,
    output logic              misaligned,
    output logic              ro_err
);

    logic [APB_AW-1:0] offset;
    logic              ro_bit;

    always_comb begin
        offset     = paddr - BASE_ADDR;
        hit        = offset < APB_AW'(4 * NREG);
        misaligned = |paddr[1:0];
        idx        = offset[IDX_W+1:2];
        ro_bit     = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDX_W'(i)) begin
                ro_bit = RO_MASK[i];
            end
        end
        ro_err = pwrite & hit & ro_bit;
    end

endmodule

// File: rtl/apb_reg_ctrl.sv
// APB4 slave front-end for a small status/control register bank.
// Latches the decoded transfer at setup, counts wait states, then issues one-cycle register strobes.
module apb_reg_ctrl
    import apb_reg_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'hC0F16000,
    parameter int                NREG        = 4,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [NREG-1:0]   RO_MASK     = 4'b0010
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [APB_AW-1:0]      paddr,
    input  logic [APB_DW-1:0]      pwdata,
    input  logic [3:0]             pstrb,
    output logic [APB_DW-1:0]      prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [NREG-1:0]        reg_wr_en,
    output logic [NREG-1:0]        reg_rd_en,
    output logic [APB_DW-1:0]      reg_wdata,
    output logic [3:0]             reg_wstrb,
    input  logic [NREG*APB_DW-1:0] reg_rdata
);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx_q, dec_idx;
    logic             dir_q, err_q;
    logic             dec_hit, dec_misaligned, dec_ro_err;
    logic             setup;
    logic [NREG-1:0]  idx_onehot;
    logic [APB_DW-1:0] rd_word;

    apb_reg_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NREG      (NREG),
        .RO_MASK   (RO_MASK)
    ) u_decode (
        .paddr      (paddr),
        .pwrite     (pwrite),
        .idx        (dec_idx),
        .hit        (dec_hit),
        .misaligned (dec_misaligned),
        .ro_err     (dec_ro_err)
    );

    assign setup     = psel & ~penable;
    assign reg_wdata = pwdata;
    assign reg_wstrb = pstrb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transfer attributes are captured once at setup; later bus changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            idx_q <= '0;
            dir_q <= 1'b0;
            err_q <= 1'b0;
        end else if (state == IDLE && setup) begin
            cnt   <= CNT_W'(WAIT_CYCLES);
            idx_q <= dec_idx;
            dir_q <= pwrite;
            err_q <= ~dec_hit | dec_misaligned | dec_ro_err;
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        idx_onehot = '0;
        rd_word    = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx_q == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
                rd_word       = reg_rdata[APB_DW*i +: APB_DW];
            end
        end
    end

    // pready depends only on registered state; strobes additionally need the completing handshake.
    always_comb begin
        next_state = state;
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata     = '0;
        reg_wr_en  = '0;
        reg_rd_en  = '0;
        case (state)
            IDLE: begin
                if (setup) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                pready  = (cnt == '0);
                pslverr = pready & err_q;
                if (!dir_q && !err_q) begin
                    prdata = rd_word;
                end
                if (!psel) begin
                    next_state = IDLE;
                end else if (penable && pready) begin
                    next_state = IDLE;
                    if (!err_q) begin
                        if (dir_q) begin
                            reg_wr_en = idx_onehot;
                        end else begin
                            reg_rd_en = idx_onehot;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Directed bench for apb_reg_ctrl: three instances (WAIT_CYCLES 0, 2, 3) on a shared bus with private psel.
// Register 1 is modelled as a read-to-clear status register.
module tb_apb_reg_ctrl;
    import apb_reg_pkg::*;

    localparam logic [31:0] BASE = 32'hC0F16000;

    typedef struct {
        int          dut;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] rdata;
        bit          err;
        logic [3:0]  rd;
        logic [3:0]  wr_en;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [127:0] reg_rdata;

    logic [31:0] prdata_a [3];
    logic        pready_a [3];
    logic        pslverr_a [3];
    logic [3:0]  wr_a [3];
    logic [3:0]  rd_a [3];
    logic [31:0] wdata_a [3];
    logic [3:0]  wstrb_a [3];

    logic [31:0] reg1;
    logic        reload;
    int          cyc;
    int          last_done;
    int          n_checks;
    int          n_fails;
    vec_t        vecs [12];

    apb_reg_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[0]),
        .pready(pready_a[0]), .pslverr(pslverr_a[0]), .reg_wr_en(wr_a[0]), .reg_rd_en(rd_a[0]),
        .reg_wdata(wdata_a[0]), .reg_wstrb(wstrb_a[0]), .reg_rdata(reg_rdata)
    );

    apb_reg_ctrl #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[1]),
        .pready(pready_a[1]), .pslverr(pslverr_a[1]), .reg_wr_en(wr_a[1]), .reg_rd_en(rd_a[1]),
        .reg_wdata(wdata_a[1]), .reg_wstrb(wstrb_a[1]), .reg_rdata(reg_rdata)
    );

    apb_reg_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a[2]),
        .pready(pready_a[2]), .pslverr(pslverr_a[2]), .reg_wr_en(wr_a[2]), .reg_rd_en(rd_a[2]),
        .reg_wdata(wdata_a[2]), .reg_wstrb(wstrb_a[2]), .reg_rdata(reg_rdata)
    );

    assign reg_rdata = {32'hCAFEF00D, 32'hDEADBEEF, reg1, 32'h000000A5};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reload) begin
            reg1 <= 32'h00003005;
        end else if (rd_a[0][1] | rd_a[1][1] | rd_a[2][1]) begin
            reg1 <= 32'h0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transfer starting #1 after a rising edge; returns #1 after the edge that ends it.
    task automatic applyStimulus(input string tag, input vec_t v);
        int waits;
        bit done;
        waits = 0;
        done  = 1'b0;
        psel_v[v.dut] = 1'b1;
        penable = 1'b0;
        pwrite  = v.wr;
        paddr   = v.addr;
        pwdata  = v.wdata;
        pstrb   = v.strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (pready_a[v.dut]) begin
                done = 1'b1;
                last_done = cyc;
                checkOutput({tag, " waits"}, 32'(waits), 32'(v.waits));
                checkOutput({tag, " pslverr"}, 32'(pslverr_a[v.dut]), 32'(v.err));
                checkOutput({tag, " prdata"}, prdata_a[v.dut], v.rdata);
                checkOutput({tag, " rd_en"}, 32'(rd_a[v.dut]), 32'(v.rd));
                checkOutput({tag, " wr_en"}, 32'(wr_a[v.dut]), 32'(v.wr_en));
                if (v.wr_en != 4'b0) begin
                    checkOutput({tag, " wdata"}, wdata_a[v.dut], v.wdata);
                    checkOutput({tag, " wstrb"}, 32'(wstrb_a[v.dut]), 32'(v.strb));
                end
            end else begin
                waits++;
                checkOutput({tag, " wait strobes"}, 32'({rd_a[v.dut], wr_a[v.dut]}), 32'h0);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checkOutput({tag, " pready timeout"}, 32'h0, 32'h1);
        end
        checkOutput({tag, " strobe one cycle"}, 32'({rd_a[v.dut], wr_a[v.dut]}), 32'h0);
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   t1;
        n_checks  = 0;
        n_fails   = 0;
        last_done = 0;
        cyc       = 0;

        //            dut wr addr                          wdata          strb  wt rdata          err rd      wr
        vecs[0]  = '{0, 1'b0, BASE + 32'(REG_STAT_OFS), 32'h0,        4'hF, 0, 32'h00003005, 1'b0, 4'b0010, 4'b0000};
        vecs[1]  = '{1, 1'b1, BASE + 32'(REG_CTRL_OFS), 32'h000000A5, 4'hF, 2, 32'h0,        1'b0, 4'b0000, 4'b0001};
        vecs[2]  = '{0, 1'b0, BASE + 32'h010,           32'h0,        4'hF, 0, 32'h0,        1'b1, 4'b0000, 4'b0000};
        vecs[3]  = '{0, 1'b0, BASE + 32'h002,           32'h0,        4'hF, 0, 32'h0,        1'b1, 4'b0000, 4'b0000};
        vecs[4]  = '{0, 1'b1, BASE + 32'h004,           32'h11223344, 4'hF, 0, 32'h0,        1'b1, 4'b0000, 4'b0000};
        vecs[5]  = '{0, 1'b0, BASE + 32'h008,           32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 4'b0100, 4'b0000};
        vecs[6]  = '{0, 1'b1, BASE + 32'h00C,           32'h12345678, 4'h0, 0, 32'h0,        1'b0, 4'b0000, 4'b1000};
        vecs[7]  = '{0, 1'b0, BASE - 32'h004,           32'h0,        4'hF, 0, 32'h0,        1'b1, 4'b0000, 4'b0000};
        vecs[8]  = '{2, 1'b0, BASE + 32'h00C,           32'h0,        4'hF, 3, 32'hCAFEF00D, 1'b0, 4'b1000, 4'b0000};
        vecs[9]  = '{0, 1'b1, BASE + 32'h008,           32'h0BADF00D, 4'h3, 0, 32'h0,        1'b0, 4'b0000, 4'b0100};
        vecs[10] = '{1, 1'b0, BASE + 32'h000,           32'h0,        4'hF, 2, 32'h000000A5, 1'b0, 4'b0001, 4'b0000};
        vecs[11] = '{0, 1'b1, BASE + 32'h00E,           32'h5A5A5A5A, 4'hF, 0, 32'h0,        1'b1, 4'b0000, 4'b0000};

        // Reset held with all selects asserted: every output must stay quiet.
        rstn    = 1'b0;
        reload  = 1'b1;
        psel_v  = 3'b111;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = BASE + 32'h004;
        pwdata  = 32'h0;
        pstrb   = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            penable = ~penable;
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("reset dut%0d outputs", d),
                            {prdata_a[d][31:10] | prdata_a[d][9:0], pready_a[d], pslverr_a[d], rd_a[d], wr_a[d]},
                            32'h0);
            end
        end
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        reload  = 1'b0;
        rstn    = 1'b1;
        @(posedge clk); #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
        end

        $display("[TB] abort sequence");
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = BASE;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checkOutput("abort first access pready", 32'(pready_a[2]), 32'h0);
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("abort quiet", 32'({pready_a[2], pslverr_a[2], rd_a[2], wr_a[2]}), 32'h0);
        end
        @(posedge clk); #1;
        applyStimulus("after abort", vecs[8]);

        $display("[TB] reset mid-wait");
        @(posedge clk); #1;
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = BASE + 32'h00C;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        checkOutput("midwait prdata before reset", prdata_a[2], 32'hCAFEF00D);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midwait prdata async reset", prdata_a[2], 32'h0);
        checkOutput("midwait flags async reset", 32'({pready_a[2], pslverr_a[2], rd_a[2], wr_a[2]}), 32'h0);
        @(posedge clk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
        rstn    = 1'b1;
        @(posedge clk); #1;
        applyStimulus("after reset", vecs[8]);

        $display("[TB] back-to-back read-to-clear");
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        v = vecs[0];
        applyStimulus("b2b first", v);
        t1 = last_done;
        v.rdata = 32'h0;
        applyStimulus("b2b second", v);
        checkOutput("b2b strobe spacing", 32'(last_done - t1), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
